// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Pixel-timing generator for the 640x480 @ 60 Hz display path. Counts pixel
// clocks into a horizontal/vertical raster position. It produces the active-low
// sync pulses, the visible-area enable and the current pixel coordinates.
//
// Ports:
//   vga_clk      in   1   pixel clock (25 MHz nominal); all logic on posedge
//   reset        in   1   synchronous, active-high
//   hs           out  1   horizontal sync, active low
//   vs           out  1   vertical sync, active low
//   blank        out  1   1 = current pixel is in the visible area
//   DrawX        out  10  horizontal position, 0..H_TOTAL-1
//   DrawY        out  10  vertical position, 0..V_TOTAL-1
//   frame_start  out  1   one-cycle pulse at pixel (0,0)
//   frame_count  out  8   completed-frame counter, wraps 255 -> 0
//
// Optional feature macro: VGA_FRAME_CNT_EN
//   Defined   : frame_start / frame_count are generated.
//   Undefined : both are tied to 0 and no counter logic is built. The ports
//               stay so that parent modules do not change.
//
// After reset is released, the first clock holds the raster at (0,0). That
// clock is the first frame_start. DrawX then counts 1, 2, ... from the next
// clock onward.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Low during reset. It stays low for the first clock after release, so that
    // clock re-enters the raster at (0,0).
    logic       running;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;

    // Next raster position. The registered sync/blank outputs are decoded from
    // this value, so they describe the same pixel as DrawX/DrawY.
    always_comb begin
        // NOTE: defaults first so every path assigns x_nxt/y_nxt (no latch).
        x_nxt = DrawX;
        y_nxt = DrawY;
        if (!running) begin
            x_nxt = '0;
            y_nxt = '0;
        end else if (DrawX == H_LAST) begin
            x_nxt = '0;
            y_nxt = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
        end else begin
            x_nxt = DrawX + 10'd1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all registered state.
            running <= 1'b0;
            DrawX   <= '0;
            DrawY   <= '0;
            hs      <= 1'b1;
            vs      <= 1'b1;
            blank   <= 1'b1;
        end else begin
            running <= 1'b1;
            DrawX   <= x_nxt;
            DrawY   <= y_nxt;
            hs      <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
            vs      <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
            blank   <= (x_nxt < H_VIS_END) && (y_nxt < V_VIS_END);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
            // Counts only real end-of-frame wraps, not the restart after reset.
            if (running && (DrawX == H_LAST) && (DrawY == V_LAST))
                frame_count <= frame_count + 8'd1;
        end
    end
`else
    assign frame_start = 1'b0;
    assign frame_count = 8'd0;
`endif

endmodule
